// File: rtl/cmd_tx_pkg.sv
// Shared constants, FSM state encoding and command byte helper for cmd_tx.
package cmd_tx_pkg;

  localparam logic [2:0]  OPC_ACC   = 3'd2;
  localparam int unsigned CMD_BYTES = 6;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSend = 3'd1,
    StGap  = 3'd2,
    StWait = 3'd3,
    StResp = 3'd4
  } state_e;

  // Byte idx of a command word, lowest byte at idx 0.
  function automatic logic [7:0] cmd_byte(input logic [47:0] c, input logic [2:0] idx);
    logic [47:0] sh;
    sh = c >> {idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/cmd_tx_timeout_cnt.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags expiry on the cycle the count reaches TIMEOUT.
module timeout_cnt #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // The cycle after clear holds count 0, so expiry lands TIMEOUT edges after clear.
  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

  // Count enabled cycles; saturate once expired.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_tx.sv
// Command transmitter: serialises a 6-byte command to a UART transmitter and,
// for ACC commands, collects a fixed-length response with an inter-byte timeout.
module cmd_tx
  import cmd_tx_pkg::*;
#(
  parameter int unsigned RESP_BYTES = 16,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         start,
  input  logic [47:0]  cmd,
  output logic         ready,
  output logic [7:0]   tx_data,
  output logic         tx_send,
  input  logic         tx_busy,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] resp,
  output logic         done,
  output logic         timeout,
  output logic [4:0]   rx_count
);

  localparam logic [2:0] LAST_IDX  = 3'(CMD_BYTES - 1);
  localparam logic [4:0] LAST_RESP = 5'(RESP_BYTES - 1);

  state_e      state_q;
  logic [47:0] cmd_q;
  logic [2:0]  byte_idx_q;
  logic        tc_clear;
  logic        tc_enable;
  logic        tc_expired;

  assign ready = (state_q == StIdle);

  // Strobe is combinational so it can only ever be high while in SEND.
  assign tx_send = (state_q == StSend) && !tx_busy;

  // Counter runs only in RESP; it restarts on entry and on every accepted byte.
  assign tc_enable = (state_q == StResp);
  assign tc_clear  = (state_q != StResp) || rx_valid;

  timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .nRst    (nRst),
    .clear   (tc_clear),
    .enable  (tc_enable),
    .expired (tc_expired)
  );

  // Transaction FSM with registered byte, response and status outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      byte_idx_q <= '0;
      tx_data    <= '0;
      resp       <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      rx_count   <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cmd_q      <= cmd;
            tx_data    <= cmd[7:0];
            byte_idx_q <= '0;
            rx_count   <= '0;
            resp       <= '0;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (!tx_busy) state_q <= StGap;
        end
        // Gives the transmitter one cycle to raise busy before it is looked at.
        StGap: begin
          state_q <= StWait;
        end
        StWait: begin
          if (!tx_busy) begin
            if (byte_idx_q != LAST_IDX) begin
              byte_idx_q <= byte_idx_q + 3'd1;
              tx_data    <= cmd_byte(cmd_q, byte_idx_q + 3'd1);
              state_q    <= StSend;
            end else if (cmd_q[10:8] == OPC_ACC) begin
              state_q <= StResp;
            end else begin
              done    <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StResp: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            resp[{rx_count[3:0], 3'b000} +: 8] <= rx_data;
            rx_count <= rx_count + 5'd1;
            if (rx_count == LAST_RESP) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end
          end else if (tc_expired) begin
            timeout <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/cmd_tx.md
CMD_TX -- requirements
Module: cmd_tx

Interface
REQ-001 SHALL have parameter RESP_BYTES, default 16: number of response bytes expected after an ACC command.
REQ-002 SHALL have parameter TIMEOUT, default 50000: maximum clock cycles allowed between successive response bytes.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port nRst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to send cmd.
REQ-006 SHALL have port cmd, input, 48: command word; [7:0] address, [10:8] opcode, [15:11] reserved, [47:16] payload.
REQ-007 SHALL have port ready, output, 1: high when idle and able to accept start.
REQ-008 SHALL have port tx_data, output, 8: byte presented to the UART transmitter.
REQ-009 SHALL have port tx_send, output, 1: one-cycle strobe loading tx_data into the UART transmitter.
REQ-010 SHALL have port tx_busy, input, 1: UART transmitter busy.
REQ-011 SHALL have port rx_data, input, 8: byte from the UART receiver.
REQ-012 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-013 SHALL have port resp, output, 128: assembled response; byte k is at [8k+7:8k].
REQ-014 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-015 SHALL have port timeout, output, 1: one-cycle pulse on response timeout.
REQ-016 SHALL have port rx_count, output, 5: number of response bytes received in the current or last transaction.

Function
REQ-017 SHALL implement states IDLE, SEND, GAP, WAIT, RESP, with ready = (state == IDLE).
REQ-018 SHALL, in IDLE on start, register cmd internally, clear rx_count, and move to SEND; start in any other state is ignored.
REQ-019 SHALL send 6 bytes, byte i = cmd[8i+7:8i], lowest byte first.
REQ-020 SHALL, in SEND, drive tx_data with the current byte and pulse tx_send for exactly one cycle when tx_busy = 0, then move to GAP; if tx_busy = 1, it holds in SEND.
REQ-021 SHALL spend exactly one cycle in GAP, ignoring tx_busy, then move to WAIT.
REQ-022 SHALL, in WAIT with tx_busy = 0, take one of three transitions:
- more bytes remain: go to SEND with the next byte;
- 6th byte done and opcode == ACC (3'd2): go to RESP;
- 6th byte done and any other opcode: pulse done, go to IDLE.
REQ-023 SHALL, in RESP, write rx_data into resp byte rx_count on each rx_valid and increment rx_count.
REQ-024 SHALL, on receipt of byte RESP_BYTES-1 in RESP, pulse done on the following cycle and go to IDLE.
REQ-025 SHALL ignore rx_valid in every state except RESP.
REQ-026 SHALL, in RESP, count cycles since entry or since the last rx_valid; when the count reaches TIMEOUT it pulses timeout, goes to IDLE, and does not pulse done.
REQ-027 SHALL, when rx_valid and timeout expiry coincide, accept the byte and restart the count without flagging timeout.
REQ-028 SHALL hold resp stable from the end of a transaction until the next accepted start; bytes received before a timeout are retained, and rx_count shows how many arrived.
REQ-029 SHALL never assert done and timeout in the same cycle, and shall never assert tx_send outside SEND.

Reset
REQ-030 SHALL asynchronously, on nRst low, force state IDLE, ready 1, tx_send 0, tx_data 0, resp 0, done 0, timeout 0, rx_count 0, and clear the timeout counter.
REQ-031 SHALL, on reset mid-transaction, abandon the transaction with no further tx_send; after release it waits for a new start.

Structure
REQ-032 SHALL take OPC_ACC = 3'd2, CMD_BYTES = 6 and the state encodings from the shared MLH constants package, which the ctrl block also uses.
REQ-033 SHALL implement the inter-byte timeout as a sub-module timeout_cnt with inputs clear and enable and output expired.

Verification
REQ-034 SHALL cover: cmd = 48'h0000_1234_0105 (opcode 1) with a UART model busy for 10 cycles per byte -> tx bytes 05,01,34,12,00,00, then one done pulse and no RESP entry.
REQ-035 SHALL cover: ACC cmd 48'hDEAD_BEEF_0203 followed by 16 rx bytes 00..0F -> resp = 128'h0F0E..0100, rx_count 16, done 1 pulse.
REQ-036 SHALL cover: ACC cmd with only 5 rx bytes and TIMEOUT = 100 -> timeout pulse 100 cycles after the 5th byte, rx_count 5, no done.
REQ-037 SHALL cover: start pulsed while a transaction is in progress, and rx_valid pulsed in IDLE -> no effect on the tx byte sequence, resp or rx_count.
REQ-038 SHALL cover: nRst low after the 3rd tx_send -> outputs at reset values immediately, no further tx_send; the next start sends all 6 bytes.
REQ-039 SHALL cover: rx_valid on the exact timeout-expiry cycle -> byte stored, no timeout pulse.
